// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and types for the sample buffer
package audio_pkg;
    localparam int sample_width_c   = 24;
    localparam int underrun_width_c = 16;
    localparam bit mode_mono_c      = 1'b0;
    localparam bit mode_stereo_c    = 1'b1;

    typedef logic [sample_width_c-1:0] sample_t;
endpackage

// File: rtl/i2s_sample_buffer_if.sv
// rtl/i2s_sample_buffer_if.sv - producer stream, frame clock and held output words
interface i2s_sample_buffer_if #(
    parameter int width_p = 24,
    parameter int depth_p = 8
);
    import audio_pkg::*;

    localparam int count_w_lp = $clog2(depth_p) + 1;

    logic                        valid_i;
    logic [width_p-1:0]          data_i;
    logic                        ready_o;
    logic                        lrclk_i;
    logic [width_p-1:0]          data_l_o;
    logic [width_p-1:0]          data_r_o;
    logic [count_w_lp-1:0]       count_o;
    logic                        underrun_o;
    logic [underrun_width_c-1:0] underrun_count_o;

    modport master (
        output valid_i, data_i, lrclk_i,
        input  ready_o, data_l_o, data_r_o, count_o, underrun_o, underrun_count_o
    );

    modport slave (
        input  valid_i, data_i, lrclk_i,
        output ready_o, data_l_o, data_r_o, count_o, underrun_o, underrun_count_o
    );
endinterface

// File: rtl/fifo_sync_1r1w.sv
// rtl/fifo_sync_1r1w.sv - single-clock FIFO with wrap-bit pointers
module fifo_sync_1r1w #(
    parameter int width_p = 24,
    parameter int depth_p = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [width_p-1:0]         wr_data,
    input  logic                       rd_en,
    output logic [width_p-1:0]         rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth_p):0]   count
);
    localparam int addr_w_lp = $clog2(depth_p);
    localparam logic [addr_w_lp:0] ptr_one_lp = 1;

    logic [addr_w_lp:0] wr_ptr;
    logic [addr_w_lp:0] rd_ptr;
    logic [width_p-1:0] mem [depth_p];
    logic               do_wr;
    logic               do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[addr_w_lp] != rd_ptr[addr_w_lp]) &&
                   (wr_ptr[addr_w_lp-1:0] == rd_ptr[addr_w_lp-1:0]);
    assign count = wr_ptr - rd_ptr;

    // Read side never sees the same-cycle write, so an empty FIFO stays empty for the pop.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[addr_w_lp-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[addr_w_lp-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + ptr_one_lp;
            if (do_rd) rd_ptr <= rd_ptr + ptr_one_lp;
        end
    end
endmodule

// File: rtl/i2s_sample_buffer.sv
// rtl/i2s_sample_buffer.sv - elastic sample FIFO released by the I2S frame clock
module i2s_sample_buffer
    import audio_pkg::*;
#(
    parameter int width_p  = sample_width_c,
    parameter int depth_p  = 8,
    parameter bit stereo_p = mode_mono_c
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    i2s_sample_buffer_if.slave  bus
);
    localparam logic [underrun_width_c-1:0] uc_one_lp = 1;
    localparam logic [underrun_width_c-1:0] uc_max_lp = '1;

    logic                        lrclk_s1, lrclk_s2, lrclk_s3;
    logic [1:0]                  arm_cnt;
    logic                        armed;
    logic                        fall_q, rise_q;
    logic                        pop_l, pop_r, pop_req;
    logic                        fifo_full, fifo_empty;
    logic [width_p-1:0]          fifo_rdata;
    logic [width_p-1:0]          data_l_q, data_r_q;
    logic                        underrun_q;
    logic [underrun_width_c-1:0] underrun_cnt_q;

    fifo_sync_1r1w #(
        .width_p (width_p),
        .depth_p (depth_p)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (reset_ni),
        .wr_en   (bus.valid_i),
        .wr_data (bus.data_i),
        .rd_en   (pop_req),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (bus.count_o)
    );

    // Strobes stay masked until the edge register holds a post-reset sample,
    // so an lrclk already high at reset release is not seen as a rising edge.
    assign armed = (arm_cnt == 2'd3);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lrclk_s1 <= 1'b0;
            lrclk_s2 <= 1'b0;
            lrclk_s3 <= 1'b0;
            arm_cnt  <= 2'd0;
            fall_q   <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            lrclk_s1 <= bus.lrclk_i;
            lrclk_s2 <= lrclk_s1;
            lrclk_s3 <= lrclk_s2;
            if (!armed) arm_cnt <= arm_cnt + 2'd1;
            fall_q   <= armed &&  lrclk_s3 && !lrclk_s2;
            rise_q   <= armed && !lrclk_s3 &&  lrclk_s2;
        end
    end

    // Mono: the left-slot edge feeds both channels. Stereo: each edge feeds its own slot.
    assign pop_l   = fall_q;
    assign pop_r   = stereo_p ? rise_q : fall_q;
    assign pop_req = pop_l || pop_r;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_l_q       <= '0;
            data_r_q       <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            underrun_q <= pop_req && fifo_empty;
            if (pop_req && !fifo_empty) begin
                if (pop_l) data_l_q <= fifo_rdata;
                if (pop_r) data_r_q <= fifo_rdata;
            end
            if (pop_req && fifo_empty && (underrun_cnt_q != uc_max_lp)) begin
                underrun_cnt_q <= underrun_cnt_q + uc_one_lp;
            end
        end
    end

    assign bus.ready_o          = !fifo_full;
    assign bus.data_l_o         = data_l_q;
    assign bus.data_r_o         = data_r_q;
    assign bus.underrun_o       = underrun_q;
    assign bus.underrun_count_o = underrun_cnt_q;
endmodule

// File: tb/tb_i2s_sample_buffer.sv
// tb/tb_i2s_sample_buffer.sv - scoreboard bench for mono and stereo sample buffers
module tb_i2s_sample_buffer;
    import audio_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_sample_buffer_if #(.width_p(24), .depth_p(8)) bus_m ();
    i2s_sample_buffer_if #(.width_p(24), .depth_p(8)) bus_s ();

    i2s_sample_buffer #(.width_p(24), .depth_p(8), .stereo_p(mode_mono_c)) u_mono (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus_m)
    );

    i2s_sample_buffer #(.width_p(24), .depth_p(8), .stereo_p(mode_stereo_c)) u_stereo (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus_s)
    );

    int n_checks = 0;
    int n_fails  = 0;

    sample_t     mq[$];
    sample_t     sq[$];
    sample_t     exp_l[2];
    sample_t     exp_r[2];
    logic [15:0] exp_uc[2];
    int          exp_ur_tot[2];
    int          ur_seen[2];

    always @(negedge clk) begin
        if (bus_m.underrun_o) ur_seen[0]++;
        if (bus_s.underrun_o) ur_seen[1]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic get_out(input bit st, output sample_t l, output sample_t r, output logic ur,
                           output logic [3:0] cnt, output logic [15:0] uc, output logic rdy);
        if (st) begin
            l = bus_s.data_l_o; r = bus_s.data_r_o; ur = bus_s.underrun_o;
            cnt = bus_s.count_o; uc = bus_s.underrun_count_o; rdy = bus_s.ready_o;
        end else begin
            l = bus_m.data_l_o; r = bus_m.data_r_o; ur = bus_m.underrun_o;
            cnt = bus_m.count_o; uc = bus_m.underrun_count_o; rdy = bus_m.ready_o;
        end
    endtask

    task automatic push(input bit st, input sample_t v);
        int n;
        logic rdy;
        n = st ? sq.size() : mq.size();
        if (st) begin bus_s.valid_i = 1'b1; bus_s.data_i = v; end
        else    begin bus_m.valid_i = 1'b1; bus_m.data_i = v; end
        #1;
        rdy = st ? bus_s.ready_o : bus_m.ready_o;
        check("ready_before_push", rdy, n < 8);
        @(posedge clk);
        if (n < 8) begin
            if (st) sq.push_back(v); else mq.push_back(v);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus_m.valid_i = 1'b0;
        bus_s.valid_i = 1'b0;
    endtask

    task automatic lr_edge(input bit st, input bit lvl);
        sample_t l, r, v;
        logic ur, rdy;
        logic [3:0] cnt;
        logic [15:0] uc;
        bit to_l, to_r, is_pop;
        int n;
        if (st) bus_s.lrclk_i = lvl; else bus_m.lrclk_i = lvl;
        to_l   = !lvl;
        to_r   = st ? lvl : !lvl;
        is_pop = to_l || to_r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        get_out(st, l, r, ur, cnt, uc, rdy);
        check("pre_update_l", l, exp_l[st]);
        check("pre_update_r", r, exp_r[st]);
        check("pre_update_underrun", ur, 1'b0);
        @(posedge clk);
        @(negedge clk);
        get_out(st, l, r, ur, cnt, uc, rdy);
        n = st ? sq.size() : mq.size();
        if (is_pop && n > 0) begin
            v = st ? sq.pop_front() : mq.pop_front();
            if (to_l) exp_l[st] = v;
            if (to_r) exp_r[st] = v;
            check("underrun_on_pop", ur, 1'b0);
        end else if (is_pop) begin
            if (exp_uc[st] != 16'hffff) exp_uc[st]++;
            exp_ur_tot[st]++;
            check("underrun_on_empty", ur, 1'b1);
        end else begin
            check("underrun_no_pop", ur, 1'b0);
        end
        n = st ? sq.size() : mq.size();
        check("data_l", l, exp_l[st]);
        check("data_r", r, exp_r[st]);
        check("count", cnt, n);
        check("ready", rdy, n < 8);
        check("underrun_count", uc, exp_uc[st]);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        sample_t l, r;
        logic ur, rdy;
        logic [3:0] cnt;
        logic [15:0] uc;
        for (int s = 0; s < 2; s++) begin
            get_out(s[0], l, r, ur, cnt, uc, rdy);
            check({tag, "_l"}, l, 0);
            check({tag, "_r"}, r, 0);
            check({tag, "_count"}, cnt, 0);
            check({tag, "_ready"}, rdy, 1'b1);
            check({tag, "_underrun"}, ur, 1'b0);
            check({tag, "_uc"}, uc, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        mq.delete();
        sq.delete();
        for (int s = 0; s < 2; s++) begin
            exp_l[s] = '0; exp_r[s] = '0; exp_uc[s] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cnt;
        for (int s = 0; s < 2; s++) begin
            exp_l[s] = '0; exp_r[s] = '0; exp_uc[s] = '0; exp_ur_tot[s] = 0; ur_seen[s] = 0;
        end
        bus_m.valid_i = 1'b0; bus_m.data_i = '0; bus_m.lrclk_i = 1'b1;
        bus_s.valid_i = 1'b0; bus_s.data_i = '0; bus_s.lrclk_i = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_pop_at_release_m", ur_seen[0], 0);
        check("no_pop_at_release_s", ur_seen[1], 0);
        check_zero("after_release");

        // mono ordering
        for (int i = 1; i <= 3; i++) push(1'b0, sample_t'(i));
        idle();
        for (int i = 0; i < 3; i++) begin
            lr_edge(1'b0, 1'b0);
            lr_edge(1'b0, 1'b1);
        end

        // underrun from fresh reset, then recovery
        do_reset();
        for (int i = 0; i < 3; i++) begin
            lr_edge(1'b0, 1'b0);
            lr_edge(1'b0, 1'b1);
        end
        check("underrun_pulses_m", ur_seen[0], exp_ur_tot[0]);
        push(1'b0, 24'h123456);
        idle();
        lr_edge(1'b0, 1'b0);
        lr_edge(1'b0, 1'b1);

        // fill to full with valid held high, then drain
        for (int i = 0; i < 9; i++) push(1'b0, sample_t'(24'h100 + i));
        idle();
        cnt = bus_m.count_o;
        check("full_count", cnt, 8);
        for (int i = 0; i < 8; i++) begin
            lr_edge(1'b0, 1'b0);
            lr_edge(1'b0, 1'b1);
        end

        // push on the exact cycle of a pop strobe into an empty FIFO
        bus_m.lrclk_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_m.valid_i = 1'b1;
        bus_m.data_i  = 24'h0000ab;
        @(posedge clk);
        @(negedge clk);
        idle();
        check("concurrent_underrun", bus_m.underrun_o, 1'b1);
        check("concurrent_count", bus_m.count_o, 1);
        check("concurrent_hold_l", bus_m.data_l_o, exp_l[0]);
        mq.push_back(24'h0000ab);
        exp_uc[0]++;
        exp_ur_tot[0]++;
        lr_edge(1'b0, 1'b1);

        // stereo steering
        push(1'b1, 24'h00aaaa);
        push(1'b1, 24'h005555);
        idle();
        lr_edge(1'b1, 1'b0);
        lr_edge(1'b1, 1'b1);
        lr_edge(1'b1, 1'b0);
        lr_edge(1'b1, 1'b1);
        check("underrun_pulses_s", ur_seen[1], exp_ur_tot[1]);

        // asynchronous reset with samples buffered
        for (int i = 0; i < 4; i++) push(1'b0, sample_t'(24'h700 + i));
        idle();
        check("midstream_count", bus_m.count_o, 5);
        do_reset();
        check("no_pop_after_reset_m", ur_seen[0], exp_ur_tot[0]);
        check("no_pop_after_reset_s", ur_seen[1], exp_ur_tot[1]);
        check_zero("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
